// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with a background line-refill FSM.
// Define ICACHE_HIT_UNDER_MISS_EN to serve hits on other lines while a refill is in flight.
module icache_ctrl #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4,
  parameter logic [31:0] SEG_LO = 32'h0000_0000,
  parameter logic [31:0] SEG_HI = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [31:0] i_addr,
  input  logic        stall,
  input  logic        inv,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic        busy,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t           state_q;
  logic [OFF_W-1:0] beat_q;
  logic             drop_q;
  logic [TAG_W-1:0] fillTag_q;
  logic [IDX_W-1:0] fillIdx_q;
  logic             memReq_q;
  logic [31:0]      data_q;
  logic             miss_q;
  logic             segf_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tagArr [LINES];
  logic [31:0]      dataArr [LINES][WORDS];

  logic [OFF_W-1:0] reqOff;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;
  logic             reqFire;
  logic             lastBeat;
  logic             segfault;
  logic             hit;

  assign reqOff   = i_addr[OFF_W+1:2];
  assign reqIdx   = i_addr[OFF_W+2 +: IDX_W];
  assign reqTag   = i_addr[31 -: TAG_W];
  assign reqFire  = i_rd && !stall;
  assign lastBeat = (beat_q == OFF_W'(WORDS - 1));

  // Offsetting by SEG_LO folds the two-sided range check into one unsigned compare.
  always_comb begin
    segfault = ((i_addr - SEG_LO) >= (SEG_HI - SEG_LO)) || (i_addr[1:0] != 2'b00);
    hit      = valid_q[reqIdx] && (tagArr[reqIdx] == reqTag);
`ifdef ICACHE_HIT_UNDER_MISS_EN
    if ((state_q != IDLE) && (reqIdx == fillIdx_q)) hit = 1'b0;
`else
    if (state_q != IDLE) hit = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      drop_q    <= 1'b0;
      fillTag_q <= '0;
      fillIdx_q <= '0;
      memReq_q  <= 1'b0;
      data_q    <= '0;
      miss_q    <= 1'b0;
      segf_q    <= 1'b0;
      valid_q   <= '0;
    end else begin
      if (!stall) begin
        if (!i_rd) begin
          miss_q <= 1'b0;
          segf_q <= 1'b0;
        end else if (segfault) begin
          miss_q <= 1'b0;
          segf_q <= 1'b1;
        end else if (hit) begin
          data_q <= dataArr[reqIdx][reqOff];
          miss_q <= 1'b0;
          segf_q <= 1'b0;
        end else begin
          miss_q <= 1'b1;
          segf_q <= 1'b0;
        end
      end

      if (inv) valid_q <= '0;

      // Misses seen while a refill is already in flight are not queued; the requester replays.
      case (state_q)
        IDLE: begin
          if (reqFire && !segfault && !hit) begin
            state_q   <= REQ;
            memReq_q  <= 1'b1;
            fillTag_q <= reqTag;
            fillIdx_q <= reqIdx;
            drop_q    <= 1'b0;
          end
        end
        REQ: begin
          if (inv) drop_q <= 1'b1;
          if (mem_rd_gnt) begin
            memReq_q <= 1'b0;
            beat_q   <= '0;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (inv) drop_q <= 1'b1;
          if (mem_rd_valid) begin
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == '0) valid_q[fillIdx_q] <= 1'b0;
            if (lastBeat) begin
              if (!drop_q && !inv) valid_q[fillIdx_q] <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what is resident.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_rd_valid) begin
      dataArr[fillIdx_q][beat_q] <= mem_rd_data;
      if (beat_q == '0) tagArr[fillIdx_q] <= fillTag_q;
    end
  end

  assign i_data     = data_q;
  assign i_miss     = miss_q;
  assign i_segfault = segf_q;
  assign busy       = (state_q != IDLE);
  assign mem_rd_req = memReq_q;
  assign mem_addr   = {fillTag_q, fillIdx_q, {(OFF_W + 2){1'b0}}};

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus a randomized run
// checked against a line-level behavioural model of the cache.
module tb_icache_ctrl;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam logic [31:0] SEGHI = 32'h0001_0000;
  localparam int LINE_BYTES = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd;
  logic [31:0] i_addr;
  logic        stall;
  logic        inv;
  logic [31:0] i_data;
  logic        i_miss;
  logic        i_segfault;
  logic        busy;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  int tests = 0;
  int fails = 0;

  icache_ctrl #(.LINES(LINES), .WORDS(WORDS), .SEG_LO(32'h0000_0000), .SEG_HI(SEGHI)) dut (
    .clk(clk), .rst(rst), .i_rd(i_rd), .i_addr(i_addr), .stall(stall), .inv(inv),
    .i_data(i_data), .i_miss(i_miss), .i_segfault(i_segfault), .busy(busy),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Backing memory image: line 0x100 holds 0xA0..0xA3, everything else a hash of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    if ((a & ~32'(LINE_BYTES - 1)) == 32'h100) w = 32'hA0 + ((a - 32'h100) >> 2);
    else w = (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    return w;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    i_rd = 1'b0; i_addr = '0; stall = 1'b0; inv = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  // Grant the pending request, then stream the line back; inv pulses with beat invBeat.
  task automatic runFill(input logic [31:0] line, input int invBeat);
    i_rd = 1'b0; mem_rd_gnt = 1'b1;
    stepClk();
    mem_rd_gnt = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = memWord(line + 32'(w * 4));
      inv          = (w == invBeat);
      stepClk();
    end
    mem_rd_valid = 1'b0; inv = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    stepClk(); stepClk();
    tests++; if (i_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h want 0", i_data); end
    tests++; if (i_miss !== 1'b0 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: miss=%b seg=%b want 0 0", i_miss, i_segfault); end
    tests++; if (busy !== 1'b0 || mem_rd_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_fsm: busy=%b req=%b want 0 0", busy, mem_rd_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
    rst = 1'b0;
    stepClk();
  endtask

  task automatic test_miss_fill();
    i_rd = 1'b1; i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL first_miss: miss=%b seg=%b want 1 0", i_miss, i_segfault); end
    tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL first_req: req=%b addr=%h want 1 00000100", mem_rd_req, mem_addr); end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL first_busy: got %b want 1", busy); end
    i_rd = 1'b0; mem_rd_gnt = 1'b1;
    stepClk();
    mem_rd_gnt = 1'b0;
    tests++; if (mem_rd_req !== 1'b0 || i_miss !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL grant: req=%b miss=%b busy=%b want 0 0 1", mem_rd_req, i_miss, busy); end
    for (int w = 0; w < WORDS; w++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'hA0 + 32'(w);
      stepClk();
    end
    mem_rd_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL fill_done_busy: got %b want 0", busy); end
    i_rd = 1'b1; i_addr = 32'h104;
    stepClk();
    tests++; if (i_data !== 32'hA1 || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL replay_hit: data=%h miss=%b want 000000a1 0", i_data, i_miss); end
    i_rd = 1'b0;
    stepClk();
  endtask

  task automatic test_segfault();
    i_rd = 1'b1; i_addr = 32'h0001_0000;
    stepClk();
    tests++; if (i_segfault !== 1'b1 || i_miss !== 1'b0 || mem_rd_req !== 1'b0) begin fails++; $display("[TB] FAIL seg_limit: seg=%b miss=%b req=%b want 1 0 0", i_segfault, i_miss, mem_rd_req); end
    i_addr = 32'h102;
    stepClk();
    tests++; if (i_segfault !== 1'b1 || i_miss !== 1'b0 || mem_rd_req !== 1'b0) begin fails++; $display("[TB] FAIL seg_align: seg=%b miss=%b req=%b want 1 0 0", i_segfault, i_miss, mem_rd_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL seg_busy: got %b want 0", busy); end
    i_rd = 1'b0;
    stepClk();
    tests++; if (i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL seg_clear: got %b want 0", i_segfault); end
  endtask

  task automatic test_evict();
    i_rd = 1'b1; i_addr = 32'h500;
    stepClk();
    tests++; if (i_miss !== 1'b1 || mem_addr !== 32'h500) begin fails++; $display("[TB] FAIL evict_miss: miss=%b addr=%h want 1 00000500", i_miss, mem_addr); end
    runFill(32'h500, -1);
    i_rd = 1'b1; i_addr = 32'h504;
    stepClk();
    tests++; if (i_data !== memWord(32'h504) || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL evict_newhit: data=%h miss=%b want %h 0", i_data, i_miss, memWord(32'h504)); end
    i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1 || mem_rd_req !== 1'b1) begin fails++; $display("[TB] FAIL evict_oldmiss: miss=%b req=%b want 1 1", i_miss, mem_rd_req); end
    runFill(32'h100, -1);
  endtask

  task automatic test_hit_under_miss();
    inv = 1'b1;
    stepClk();
    inv = 1'b0; i_rd = 1'b1; i_addr = 32'h220;
    stepClk();
    tests++; if (i_miss !== 1'b1) begin fails++; $display("[TB] FAIL hum_prefill: miss=%b want 1", i_miss); end
    runFill(32'h220, -1);
    i_rd = 1'b1; i_addr = 32'h228;
    stepClk();
    tests++; if (i_data !== memWord(32'h228) || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL hum_resident: data=%h miss=%b want %h 0", i_data, i_miss, memWord(32'h228)); end
    i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL hum_start: miss=%b busy=%b want 1 1", i_miss, busy); end
    i_rd = 1'b0; mem_rd_gnt = 1'b1;
    stepClk();
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = memWord(32'h100); i_rd = 1'b1; i_addr = 32'h224;
    stepClk();
`ifdef ICACHE_HIT_UNDER_MISS_EN
    tests++; if (i_data !== memWord(32'h224) || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL hum_other: data=%h miss=%b want %h 0", i_data, i_miss, memWord(32'h224)); end
`else
    tests++; if (i_data !== memWord(32'h228) || i_miss !== 1'b1) begin fails++; $display("[TB] FAIL hum_other: data=%h miss=%b want %h 1", i_data, i_miss, memWord(32'h228)); end
`endif
    mem_rd_data = memWord(32'h104); i_addr = 32'h108;
    stepClk();
    tests++; if (i_miss !== 1'b1 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL hum_fillline: miss=%b seg=%b want 1 0", i_miss, i_segfault); end
    mem_rd_data = memWord(32'h108); i_rd = 1'b0;
    stepClk();
    mem_rd_data = memWord(32'h10C);
    stepClk();
    mem_rd_valid = 1'b0;
    tests++; if (busy !== 1'b0 || mem_rd_req !== 1'b0) begin fails++; $display("[TB] FAIL hum_end: busy=%b req=%b want 0 0", busy, mem_rd_req); end
  endtask

  task automatic test_inv_stall();
    inv = 1'b1; i_rd = 1'b0;
    stepClk();
    inv = 1'b0; i_rd = 1'b1; i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1) begin fails++; $display("[TB] FAIL inv_clear: miss=%b want 1", i_miss); end
    runFill(32'h100, 1);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL inv_busy: got %b want 0", busy); end
    i_rd = 1'b1; i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1) begin fails++; $display("[TB] FAIL inv_drop: miss=%b want 1", i_miss); end
    runFill(32'h100, -1);
    i_rd = 1'b1; i_addr = 32'h104;
    stepClk();
    tests++; if (i_data !== 32'hA1 || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL stall_pre: data=%h miss=%b want 000000a1 0", i_data, i_miss); end
    stall = 1'b1; i_addr = 32'h0001_0000;
    stepClk();
    tests++; if (i_data !== 32'hA1 || i_miss !== 1'b0 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL stall_hold: data=%h miss=%b seg=%b want 000000a1 0 0", i_data, i_miss, i_segfault); end
    i_rd = 1'b0;
    stepClk();
    tests++; if (i_data !== 32'hA1 || i_miss !== 1'b0 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL stall_idle: data=%h miss=%b seg=%b want 000000a1 0 0", i_data, i_miss, i_segfault); end
    stall = 1'b0; i_rd = 1'b1; i_addr = 32'h102;
    stepClk();
    stall = 1'b1; i_rd = 1'b0;
    stepClk();
    tests++; if (i_segfault !== 1'b1 || i_miss !== 1'b0) begin fails++; $display("[TB] FAIL stall_seg: seg=%b miss=%b want 1 0", i_segfault, i_miss); end
    stall = 1'b0;
    stepClk();
    tests++; if (i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL stall_release: seg=%b want 0", i_segfault); end
  endtask

  task automatic test_reset_midfill();
    inv = 1'b1;
    stepClk();
    inv = 1'b0; i_rd = 1'b1; i_addr = 32'h100;
    stepClk();
    i_rd = 1'b0; mem_rd_gnt = 1'b1;
    stepClk();
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = memWord(32'h100);
    stepClk();
    mem_rd_data = memWord(32'h104);
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || mem_rd_req !== 1'b0 || mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL rst_fsm: busy=%b req=%b addr=%h want 0 0 0", busy, mem_rd_req, mem_addr); end
    tests++; if (i_data !== 32'h0 || i_miss !== 1'b0 || i_segfault !== 1'b0) begin fails++; $display("[TB] FAIL rst_resp: data=%h miss=%b seg=%b want 0 0 0", i_data, i_miss, i_segfault); end
    stepClk();
    rst = 1'b0;
    stepClk(); stepClk(); stepClk();
    mem_rd_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_stray: busy=%b want 0", busy); end
    i_rd = 1'b1; i_addr = 32'h100;
    stepClk();
    tests++; if (i_miss !== 1'b1 || mem_rd_req !== 1'b1) begin fails++; $display("[TB] FAIL rst_replay: miss=%b req=%b want 1 1", i_miss, mem_rd_req); end
    i_rd = 1'b0;
  endtask

  // Line-level model: resident line address per slot, plus one in-flight refill.
  task automatic test_random();
    bit          resValid [LINES];
    logic [31:0] resLine  [LINES];
    int          phase;
    int          mBeat;
    bit          mDrop;
    logic [31:0] mLine;
    logic [31:0] eData;
    bit          eMiss, eSeg;
    logic [31:0] a, lineA;
    int          slot, sel, prePhase;
    bit          rd, st, iv, gnt, vld, seg, hit, startFill;

    idleInputs();
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    stepClk();
    for (int i = 0; i < LINES; i++) begin resValid[i] = 1'b0; resLine[i] = '0; end
    phase = 0; mBeat = 0; mDrop = 1'b0; mLine = '0;
    eData = '0; eMiss = 1'b0; eSeg = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      rd  = ($urandom_range(0, 9) < 7);
      st  = ($urandom_range(0, 9) == 0);
      iv  = ($urandom_range(0, 39) == 0);
      gnt = $urandom_range(0, 1) == 1;
      vld = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 19);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if (sel == 0) a = SEGHI + (32'($urandom_range(0, 1023)) << 2);
      else if (sel == 1) a = a | 32'($urandom_range(1, 3));

      i_rd = rd; i_addr = a; stall = st; inv = iv; mem_rd_gnt = gnt; mem_rd_valid = vld;
      mem_rd_data = (phase == 2) ? memWord(mLine + 32'(mBeat * 4)) : $urandom;

      lineA = a & ~32'(LINE_BYTES - 1);
      slot  = int'((a / LINE_BYTES) % LINES);
      seg   = (a >= SEGHI) || (a % 4 != 0);
      prePhase  = phase;
      startFill = 1'b0;

      if (!st) begin
        if (!rd) begin
          eMiss = 1'b0; eSeg = 1'b0;
        end else if (seg) begin
          eMiss = 1'b0; eSeg = 1'b1;
        end else begin
          hit = resValid[slot] && (resLine[slot] == lineA);
`ifdef ICACHE_HIT_UNDER_MISS_EN
          if (prePhase != 0 && slot == int'((mLine / LINE_BYTES) % LINES)) hit = 1'b0;
`else
          if (prePhase != 0) hit = 1'b0;
`endif
          eSeg = 1'b0;
          if (hit) begin
            eData = memWord(a); eMiss = 1'b0;
          end else begin
            eMiss = 1'b1;
            startFill = (prePhase == 0);
          end
        end
      end

      if (iv) begin
        for (int i = 0; i < LINES; i++) resValid[i] = 1'b0;
        if (prePhase != 0) mDrop = 1'b1;
      end

      if (prePhase == 1 && gnt) begin
        phase = 2; mBeat = 0;
      end else if (prePhase == 2 && vld) begin
        if (mBeat == WORDS - 1) begin
          if (!mDrop) begin
            resValid[(mLine / LINE_BYTES) % LINES] = 1'b1;
            resLine[(mLine / LINE_BYTES) % LINES]  = mLine;
          end
          phase = 0;
        end else begin
          mBeat++;
        end
      end

      if (startFill) begin phase = 1; mLine = lineA; mDrop = 1'b0; end

      stepClk();
      tests++; if (i_miss !== eMiss || i_segfault !== eSeg) begin fails++; $display("[TB] FAIL rnd_flags cyc %0d: miss=%b seg=%b want %b %b", cyc, i_miss, i_segfault, eMiss, eSeg); end
      tests++; if (i_data !== eData) begin fails++; $display("[TB] FAIL rnd_data cyc %0d: got %h want %h", cyc, i_data, eData); end
      tests++; if (busy !== (phase != 0)) begin fails++; $display("[TB] FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, phase != 0); end
      tests++; if (mem_rd_req !== (phase == 1)) begin fails++; $display("[TB] FAIL rnd_req cyc %0d: got %b want %b", cyc, mem_rd_req, phase == 1); end
      if (phase == 1) begin
        tests++; if (mem_addr !== mLine) begin fails++; $display("[TB] FAIL rnd_addr cyc %0d: got %h want %h", cyc, mem_addr, mLine); end
      end
    end
    idleInputs();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_miss_fill();
    test_segfault();
    test_evict();
    test_hit_under_miss();
    test_inv_stall();
    test_reset_midfill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
